uart_aes_loader: RTL
====================

Name: uart_aes_loader

Overview:
Command/frame controller between the UART receiver and the AES-128 encryption core. It edge-detects completed receiver bytes and decodes a one-byte command. It assembles 16-byte key or plaintext frames, MSB-first, into 128-bit registers. It then issues a one-cycle key load or encryption start to the core, honouring the core's busy flag. Inter-byte timeout and error counting guard against broken frames.

Parameters:
timeout_cycles, 24'd12500, max uart_clock cycles allowed between bytes inside a frame (100 byte-times at 50 MHz / 4 Mbaud)
cmd_key, 8'h4B, command byte ('K') that opens a 16-byte key frame
cmd_data, 8'h50, command byte ('P') that opens a 16-byte plaintext frame

Ports:
uart_clock  in  1  system clock
uart_reset  in  1  synchronous, active-low reset
rx_data  in  8  received byte from UART receiver, stable while rx_valid high
rx_valid  in  1  receiver valid level; may stay high for several cycles per byte
aes_busy  in  1  AES core busy; block_start must not be issued while high
key_out  out  128  last complete key, first received byte in [127:120]
key_load  out  1  one-cycle pulse: key_out newly valid
block_out  out  128  last complete plaintext block, first byte in [127:120]
block_start  out  1  one-cycle pulse: start encryption of block_out
ctrl_busy  out  1  high whenever state != IDLE
frame_error  out  1  one-cycle pulse on any protocol error
err_count  out  8  saturating count of frame_error pulses

Behaviour:
- One clock, uart_clock. Reset is synchronous and active-low on uart_reset, sampled on the rising edge.
- Reset values: all outputs 0; state IDLE; byte_cnt 0; timeout counter 0; rx_valid_q = 1.
- rx_valid_q = 1 at reset means a level held across reset release is not a byte.
- Byte event = rx_valid & ~rx_valid_q, with rx_valid_q registered every cycle. Exactly one event per rising edge of rx_valid.
- Internal 128-bit shift buffer: on each accepted frame byte, buf <= {buf[119:0], rx_data}.
- key_out and block_out change only on frame completion. Partial or aborted frames never alter them.
- States:
  - IDLE:
    - event with rx_data==cmd_key -> RX_KEY.
    - event with rx_data==cmd_data -> RX_DATA.
    - any other byte -> stay IDLE, frame_error.
    - byte_cnt and timeout counter are cleared on entry to RX_*.
  - RX_KEY / RX_DATA:
    - each event shifts the byte in, byte_cnt++, timeout counter cleared.
    - no event: timeout counter++.
  - Frame completion on the 16th byte (byte_cnt==15 with an event), RX_KEY: key_out <= {buf[119:0], rx_data}, key_load=1 the next cycle, -> IDLE.
  - Frame completion on the 16th byte, RX_DATA: block_out <= {buf[119:0], rx_data}.
    - aes_busy==0 at that edge: block_start=1 the next cycle, -> IDLE.
    - otherwise -> WAIT_CORE.
  - WAIT_CORE:
    - on the edge where aes_busy==0 -> block_start=1 the next cycle, -> IDLE.
    - byte events here are dropped with frame_error.
- Timeout: in RX_* with no event and counter==timeout_cycles-1 -> IDLE, frame_error, buffer discarded. No timeout applies in IDLE or WAIT_CORE.
- Simultaneous byte event and timeout expiry: the byte wins; it is accepted and the counter is cleared.
- key_load and block_start are each exactly one cycle and never asserted together.
- Latency: last rx_valid rising edge sampled at edge N -> key_load/block_start high in cycle N+1 when the core is idle.
- err_count increments on every frame_error pulse and holds at 8'hFF.
- Reset asserted mid-frame: next cycle state IDLE, all outputs 0, the partial frame is lost; key_out and block_out are cleared to 0.

Test Plan:
- Key frame: send 0x4B then bytes 0x00..0x0F -> key_out=128'h000102030405060708090A0B0C0D0E0F, key_load high exactly 1 cycle, ctrl_busy low afterwards.
- Data frame, aes_busy=0: send 0x50 then 0xF0..0xFF -> block_out=128'hF0F1...FF, block_start 1 cycle after the 16th byte. Hold rx_valid high 3 cycles per byte -> still 16 bytes counted.
- Data frame, aes_busy=1 held 50 cycles after the last byte -> state WAIT_CORE, no block_start. A stray byte during WAIT_CORE -> frame_error, err_count=1. block_start appears 1 cycle after aes_busy falls.
- Timeout: send 0x4B plus 5 bytes, then idle for timeout_cycles -> frame_error pulse, IDLE, key_out unchanged. Then a full valid key frame -> correct key_load.
- Bad command: send 0x33 -> frame_error, err_count++, stays IDLE. Drive 300 errors -> err_count saturates at 8'hFF.
- Reset mid-frame after 8 data bytes -> all outputs 0, IDLE. A following full 'P' frame produces the correct block_out.

Source files
------------

// File: rtl/uart_aes_loader_if.sv
// Bus between the UART receiver / AES core and the frame loader.
// The loader takes the slave side; whoever drives bytes and busy takes the master side.
interface uart_aes_loader_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         aes_busy;
  logic [127:0] key_out;
  logic         key_load;
  logic [127:0] block_out;
  logic         block_start;
  logic         ctrl_busy;
  logic         frame_error;
  logic [7:0]   err_count;

  modport master (
    output rx_data, rx_valid, aes_busy,
    input  key_out, key_load, block_out, block_start, ctrl_busy, frame_error, err_count
  );

  modport slave (
    input  rx_data, rx_valid, aes_busy,
    output key_out, key_load, block_out, block_start, ctrl_busy, frame_error, err_count
  );
endinterface

// File: rtl/uart_aes_loader.sv
// Command/frame controller: turns UART bytes into 16-byte key or plaintext frames
// and hands them to the AES-128 core as one-cycle key_load / block_start pulses.
module uart_aes_loader #(
  parameter logic [23:0] timeout_cycles = 24'd12500,
  parameter logic [7:0]  cmd_key        = 8'h4B,
  parameter logic [7:0]  cmd_data       = 8'h50
) (
  input  logic            uart_clock,
  input  logic            uart_reset,
  uart_aes_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RX_KEY, RX_DATA, WAIT_CORE} state_e;

  state_e         state_q, state_d;
  logic [3:0]     byte_cnt_q, byte_cnt_d;
  logic [23:0]    tmo_cnt_q, tmo_cnt_d;
  logic           rx_valid_q;
  logic [127:0]   shift_q, shift_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   block_q, block_d;
  logic           key_load_q, key_load_d;
  logic           block_start_q, block_start_d;
  logic           frame_error_q, frame_error_d;
  logic [7:0]     err_count_q, err_count_d;
  logic           byte_evt;

  // rx_valid_q resets high so a level held across reset release is not a byte
  assign byte_evt = bus.rx_valid & ~rx_valid_q;

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    shift_d       = shift_q;
    key_d         = key_q;
    block_d       = block_q;
    key_load_d    = 1'b0;
    block_start_d = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (byte_evt) begin
          if (bus.rx_data == cmd_key) begin
            state_d    = RX_KEY;
            byte_cnt_d = 4'd0;
            tmo_cnt_d  = 24'd0;
          end else if (bus.rx_data == cmd_data) begin
            state_d    = RX_DATA;
            byte_cnt_d = 4'd0;
            tmo_cnt_d  = 24'd0;
          end else begin
            frame_error_d = 1'b1;
          end
        end
      end

      RX_KEY, RX_DATA: begin
        // A byte arriving on the expiry edge wins over the timeout
        if (byte_evt) begin
          shift_d    = {shift_q[119:0], bus.rx_data};
          byte_cnt_d = byte_cnt_q + 4'd1;
          tmo_cnt_d  = 24'd0;
          if (byte_cnt_q == 4'd15) begin
            if (state_q == RX_KEY) begin
              key_d      = shift_d;
              key_load_d = 1'b1;
              state_d    = IDLE;
            end else begin
              block_d = shift_d;
              if (!bus.aes_busy) begin
                block_start_d = 1'b1;
                state_d       = IDLE;
              end else begin
                state_d = WAIT_CORE;
              end
            end
          end
        end else if (tmo_cnt_q == timeout_cycles - 24'd1) begin
          state_d       = IDLE;
          tmo_cnt_d     = 24'd0;
          frame_error_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 24'd1;
        end
      end

      WAIT_CORE: begin
        if (byte_evt) begin
          frame_error_d = 1'b1;
        end
        if (!bus.aes_busy) begin
          block_start_d = 1'b1;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    err_count_d = err_count_q;
    if (frame_error_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge uart_clock) begin
    if (!uart_reset) begin
      state_q       <= IDLE;
      byte_cnt_q    <= 4'd0;
      tmo_cnt_q     <= 24'd0;
      rx_valid_q    <= 1'b1;
      shift_q       <= 128'd0;
      key_q         <= 128'd0;
      block_q       <= 128'd0;
      key_load_q    <= 1'b0;
      block_start_q <= 1'b0;
      frame_error_q <= 1'b0;
      err_count_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      rx_valid_q    <= bus.rx_valid;
      shift_q       <= shift_d;
      key_q         <= key_d;
      block_q       <= block_d;
      key_load_q    <= key_load_d;
      block_start_q <= block_start_d;
      frame_error_q <= frame_error_d;
      err_count_q   <= err_count_d;
    end
  end

  assign bus.key_out     = key_q;
  assign bus.key_load    = key_load_q;
  assign bus.block_out   = block_q;
  assign bus.block_start = block_start_q;
  assign bus.ctrl_busy   = (state_q != IDLE);
  assign bus.frame_error = frame_error_q;
  assign bus.err_count   = err_count_q;

endmodule
